// File: rtl/ibex_mem_arb_if.sv
// ibex_mem_arb_if
//   Bundles the Ibex instruction-fetch port, the Ibex load/store port, the
//   single-port RAM port and the statistics counters of ibex_mem_arb.
//   slave  : view taken by the arbiter.
//   master : view taken by the environment, which is the core plus the RAM.
//   Signal suffixes (_i/_o) are from the arbiter's point of view.
interface ibex_mem_arb_if #(
    parameter int RamAw = 14
);
    // Instruction fetch (read-only)
    logic              instr_req_i;
    logic [31:0]       instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [31:0]       instr_rdata_o;
    logic              instr_err_o;
    // Load/store
    logic              data_req_i;
    logic              data_we_i;
    logic [3:0]        data_be_i;
    logic [31:0]       data_addr_i;
    logic [31:0]       data_wdata_i;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [31:0]       data_rdata_o;
    logic              data_err_o;
    // Single-port RAM, fixed 1-cycle read latency
    logic              ram_req_o;
    logic              ram_we_o;
    logic [3:0]        ram_be_o;
    logic [RamAw-1:0]  ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic [31:0]       ram_rdata_i;
    // Saturating statistics
    logic [15:0]       instr_grant_cnt_o;
    logic [15:0]       data_grant_cnt_o;
    logic [15:0]       err_cnt_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i,
        output instr_grant_cnt_o, data_grant_cnt_o, err_cnt_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i,
        input  instr_grant_cnt_o, data_grant_cnt_o, err_cnt_o
    );
endinterface

// File: rtl/ibex_mem_arb.sv
// ibex_mem_arb
//   Arbitrates the Ibex instruction and load/store ports onto one single-port
//   RAM. At most one grant per cycle, combinational from the requests;
//   conflicts are resolved round-robin. Accesses outside the RAM window are
//   granted but not forwarded and answer with an error. Every grant produces
//   exactly one response on its own port in the following cycle, so a new
//   grant can overlap the previous response (one access per cycle).
// Ports
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : ibex_mem_arb_if.slave (instr port, data port, RAM port, counters)
// Parameters
//   RamAw   : RAM word-address width (2**RamAw 32-bit words)
//   RamBase : RAM byte base address, aligned to 4*2**RamAw
module ibex_mem_arb #(
    parameter int          RamAw   = 14,
    parameter logic [31:0] RamBase = 32'h0010_0000
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    ibex_mem_arb_if.slave  bus
);
    localparam int TagLsb = RamAw + 2;

    function automatic logic in_range(input logic [31:0] addr);
        return addr[31:TagLsb] == RamBase[31:TagLsb];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
        return (en && (val != 16'hFFFF)) ? val + 16'd1 : val;
    endfunction

    // last_q: 0 = instr granted most recently, 1 = data
    logic        last_q, last_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_owner_q, resp_owner_d;   // 0 = instr, 1 = data
    logic        resp_err_q, resp_err_d;
    logic        resp_write_q, resp_write_d;
    logic [15:0] instr_cnt_q, instr_cnt_d;
    logic [15:0] data_cnt_q, data_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic        gnt_instr, gnt_data, any_gnt;
    logic [31:0] sel_addr;
    logic        sel_in_range;
    logic        ram_req;
    logic [31:0] resp_rdata;
    logic        unused_addr_lsb;

    always_comb begin
        // Grants are gated by reset so nothing is granted while rst_ni is low.
        gnt_instr    = rst_ni & bus.instr_req_i & (~bus.data_req_i | last_q);
        gnt_data     = rst_ni & bus.data_req_i & (~bus.instr_req_i | ~last_q);
        any_gnt      = gnt_instr | gnt_data;
        sel_addr     = gnt_data ? bus.data_addr_i : bus.instr_addr_i;
        sel_in_range = in_range(sel_addr);
        ram_req      = any_gnt & sel_in_range;

        last_d       = last_q;
        if (gnt_data) begin
            last_d = 1'b1;
        end else if (gnt_instr) begin
            last_d = 1'b0;
        end

        resp_valid_d = any_gnt;
        resp_owner_d = gnt_data;
        resp_err_d   = any_gnt & ~sel_in_range;
        resp_write_d = gnt_data & bus.data_we_i;

        instr_cnt_d  = sat_inc(instr_cnt_q, gnt_instr);
        data_cnt_d   = sat_inc(data_cnt_q, gnt_data);
        err_cnt_d    = sat_inc(err_cnt_q, resp_err_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_owner_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_write_q <= 1'b0;
            instr_cnt_q  <= 16'h0;
            data_cnt_q   <= 16'h0;
            err_cnt_q    <= 16'h0;
        end else begin
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            resp_err_q   <= resp_err_d;
            resp_write_q <= resp_write_d;
            instr_cnt_q  <= instr_cnt_d;
            data_cnt_q   <= data_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    // Byte offset bits play no role in word addressing.
    assign unused_addr_lsb = ^sel_addr[1:0];

    assign bus.instr_gnt_o = gnt_instr;
    assign bus.data_gnt_o  = gnt_data;

    assign bus.ram_req_o   = ram_req;
    assign bus.ram_we_o    = ram_req & gnt_data & bus.data_we_i;
    assign bus.ram_be_o    = ram_req ? (gnt_data ? bus.data_be_i : 4'hF) : 4'h0;
    assign bus.ram_addr_o  = sel_addr[RamAw+1:2];
    assign bus.ram_wdata_o = bus.data_wdata_i;

    // RAM read data is only meaningful for forwarded reads.
    assign resp_rdata = (resp_valid_q & ~resp_err_q & ~resp_write_q) ? bus.ram_rdata_i : 32'h0;

    assign bus.instr_rvalid_o = resp_valid_q & ~resp_owner_q;
    assign bus.instr_err_o    = resp_valid_q & ~resp_owner_q & resp_err_q;
    assign bus.instr_rdata_o  = resp_owner_q ? 32'h0 : resp_rdata;

    assign bus.data_rvalid_o  = resp_valid_q & resp_owner_q;
    assign bus.data_err_o     = resp_valid_q & resp_owner_q & resp_err_q;
    assign bus.data_rdata_o   = resp_owner_q ? resp_rdata : 32'h0;

    assign bus.instr_grant_cnt_o = instr_cnt_q;
    assign bus.data_grant_cnt_o  = data_cnt_q;
    assign bus.err_cnt_o         = err_cnt_q;
endmodule

// File: tb/tb_ibex_mem_arb.sv
module tb_ibex_mem_arb;
    localparam int          AW    = 14;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h0010_0000;
    localparam logic [31:0] LIMIT = BASE + 32'h0001_0000;   // 4*DEPTH bytes

    typedef struct {
        int          due;
        bit          owner;   // 0 = instr, 1 = data
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit          m_last_data;
    logic [15:0] m_icnt, m_dcnt, m_ecnt;
    resp_t       exp_q[$];
    // Behavioural RAM attached to the DUT
    logic [31:0] ram_mem [DEPTH];
    bit          last_gd;

    ibex_mem_arb_if #(.RamAw(AW)) bus ();

    ibex_mem_arb #(.RamAw(AW), .RamBase(BASE)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.ram_req_o) begin
            if (bus.ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.ram_be_o[b]) ram_mem[bus.ram_addr_o][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
            end else begin
                bus.ram_rdata_i <= ram_mem[bus.ram_addr_o];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: pops the expected response due in this cycle.
    always @(negedge clk) begin
        resp_t e;
        bit    have;
        if (mon_en) begin
            have = 1'b0;
            e = '{due: 0, owner: 1'b0, err: 1'b0, rdata: 32'h0};
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                have = 1'b1;
            end
            check("instr_rvalid", {31'b0, bus.instr_rvalid_o}, {31'b0, have && !e.owner});
            check("data_rvalid",  {31'b0, bus.data_rvalid_o},  {31'b0, have && e.owner});
            if (have && !e.owner) begin
                check("instr_rdata", bus.instr_rdata_o, e.rdata);
                check("instr_err", {31'b0, bus.instr_err_o}, {31'b0, e.err});
            end
            if (have && e.owner) begin
                check("data_rdata", bus.data_rdata_o, e.rdata);
                check("data_err", {31'b0, bus.data_err_o}, {31'b0, e.err});
            end
        end
    end

    // Present one cycle of requests (called just after a falling edge),
    // check the same-cycle grant and RAM command, and queue the response.
    task automatic issue(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                         input logic [3:0] dbe, input logic [31:0] da, input logic [31:0] dwd);
        bit          gi, gd, inr, wr;
        logic [31:0] a, word, rd;
        check("instr_grant_cnt", {16'h0, bus.instr_grant_cnt_o}, {16'h0, m_icnt});
        check("data_grant_cnt",  {16'h0, bus.data_grant_cnt_o},  {16'h0, m_dcnt});
        check("err_cnt",         {16'h0, bus.err_cnt_o},         {16'h0, m_ecnt});
        bus.instr_req_i  = ir;
        bus.instr_addr_i = ia;
        bus.data_req_i   = dr;
        bus.data_we_i    = dwe;
        bus.data_be_i    = dbe;
        bus.data_addr_i  = da;
        bus.data_wdata_i = dwd;
        #1;
        // Round-robin: on conflict the port not served most recently wins.
        gi = ir && (!dr || m_last_data);
        gd = dr && (!ir || !m_last_data);
        last_gd = gd;
        check("instr_gnt", {31'b0, bus.instr_gnt_o}, {31'b0, gi});
        check("data_gnt",  {31'b0, bus.data_gnt_o},  {31'b0, gd});
        if (gi || gd) begin
            a    = gd ? da : ia;
            inr  = (a >= BASE) && (a < LIMIT);
            wr   = gd && dwe;
            word = (a - BASE) / 4;
            check("ram_req", {31'b0, bus.ram_req_o}, {31'b0, inr});
            if (inr) begin
                check("ram_addr", {18'b0, bus.ram_addr_o}, word);
                check("ram_we", {31'b0, bus.ram_we_o}, {31'b0, wr});
                check("ram_be", {28'b0, bus.ram_be_o}, gd ? {28'b0, dbe} : 32'hF);
                if (wr) check("ram_wdata", bus.ram_wdata_o, dwd);
            end else begin
                check("ram_we_oor", {31'b0, bus.ram_we_o}, 32'h0);
                check("ram_be_oor", {28'b0, bus.ram_be_o}, 32'h0);
            end
            rd = (inr && !wr) ? ref_mem[word] : 32'h0;
            exp_q.push_back('{due: cyc + 1, owner: gd, err: !inr, rdata: rd});
            if (inr && wr)
                for (int b = 0; b < 4; b++)
                    if (dbe[b]) ref_mem[word][8*b +: 8] = dwd[8*b +: 8];
            if (gi && m_icnt != 16'hFFFF) m_icnt++;
            if (gd && m_dcnt != 16'hFFFF) m_dcnt++;
            if (!inr && m_ecnt != 16'hFFFF) m_ecnt++;
            m_last_data = gd;
        end else begin
            check("ram_req_idle", {31'b0, bus.ram_req_o}, 32'h0);
            check("ram_be_idle", {28'b0, bus.ram_be_o}, 32'h0);
        end
    endtask

    task automatic idle();
        issue(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        exp_q.delete();
        m_last_data = 1'b1;
        m_icnt = 16'h0;
        m_dcnt = 16'h0;
        m_ecnt = 16'h0;
        bus.instr_req_i  = 1'b1;
        bus.instr_addr_i = BASE;
        bus.data_req_i   = 1'b1;
        bus.data_we_i    = 1'b1;
        bus.data_be_i    = 4'hF;
        bus.data_addr_i  = BASE + 32'h4;
        bus.data_wdata_i = 32'h0;
        #1;
        check("rst_instr_gnt", {31'b0, bus.instr_gnt_o}, 32'h0);
        check("rst_data_gnt",  {31'b0, bus.data_gnt_o},  32'h0);
        check("rst_ram_req",   {31'b0, bus.ram_req_o},   32'h0);
        check("rst_ram_we",    {31'b0, bus.ram_we_o},    32'h0);
        check("rst_ram_be",    {28'b0, bus.ram_be_o},    32'h0);
        check("rst_instr_cnt", {16'h0, bus.instr_grant_cnt_o}, 32'h0);
        check("rst_data_cnt",  {16'h0, bus.data_grant_cnt_o},  32'h0);
        check("rst_err_cnt",   {16'h0, bus.err_cnt_o},         32'h0);
        @(negedge clk);
        @(negedge clk);
        bus.instr_req_i = 1'b0;
        bus.data_req_i  = 1'b0;
        rst_ni = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 7);
        case (r)
            0: return $urandom();
            1: return BASE - 32'h4;
            2: return LIMIT;
            3: return LIMIT - 32'h4;
            default: return BASE + ($urandom_range(0, DEPTH - 1) << 2);
        endcase
    endfunction

    initial begin
        logic [5:0] seq;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = 32'hA5A5_0000 ^ (i * 32'h0001_0101);
            ram_mem[i] = ref_mem[i];
        end
        ref_mem[4] = 32'h1234_5678;
        ram_mem[4] = 32'h1234_5678;
        bus.ram_rdata_i  = 32'h0;
        bus.instr_req_i  = 1'b0;
        bus.instr_addr_i = 32'h0;
        bus.data_req_i   = 1'b0;
        bus.data_we_i    = 1'b0;
        bus.data_be_i    = 4'h0;
        bus.data_addr_i  = 32'h0;
        bus.data_wdata_i = 32'h0;
        #2;
        mon_en = 1'b1;
        do_reset();

        // Instruction read at word 4
        issue(1, 32'h0010_0010, 0, 0, 4'h0, 32'h0, 32'h0);
        check("req027_ram_addr", {18'b0, bus.ram_addr_o}, 32'd4);
        @(negedge clk);
        idle();
        check("req027_instr_cnt", {16'h0, bus.instr_grant_cnt_o}, 32'd1);

        // Continuous conflict from reset alternates I,D,I,D,I,D
        @(negedge clk);
        do_reset();
        seq = '0;
        for (int i = 0; i < 6; i++) begin
            issue(1, BASE + 32'(i * 8), 1, 0, 4'h0, BASE + 32'h100 + 32'(i * 4), 32'h0);
            seq = {seq[4:0], bus.data_gnt_o};
            @(negedge clk);
        end
        check("req028_grant_seq", {26'b0, seq}, 32'b010101);
        idle();
        check("req028_instr_cnt", {16'h0, bus.instr_grant_cnt_o}, 32'd3);
        check("req028_data_cnt",  {16'h0, bus.data_grant_cnt_o},  32'd3);

        // Partial write then read back
        issue(0, 32'h0, 1, 1, 4'b0011, 32'h0010_0008, 32'hDEAD_BEEF);
        @(negedge clk);
        issue(0, 32'h0, 1, 0, 4'hF, 32'h0010_0008, 32'h0);
        @(negedge clk);
        // Out-of-range read
        issue(0, 32'h0, 1, 0, 4'hF, 32'h0000_0000, 32'h0);
        @(negedge clk);
        idle();
        check("req030_err_cnt", {16'h0, bus.err_cnt_o}, {16'h0, m_ecnt});

        // Reset while an instruction response is outstanding
        issue(1, BASE + 32'h20, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        do_reset();
        idle();
        idle();
        issue(1, BASE + 32'h40, 1, 0, 4'hF, BASE + 32'h44, 32'h0);
        check("req031_first_conflict_instr", {31'b0, bus.instr_gnt_o}, 32'h1);
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            issue($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rand_addr(), $urandom());
            @(negedge clk);
        end
        idle();

        // Data grant counter saturation
        force dut.data_cnt_q = 16'hFFFE;
        m_dcnt = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.data_cnt_q;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            issue(0, 32'h0, 1, 0, 4'hF, BASE + 32'(i * 4), 32'h0);
            @(negedge clk);
        end
        idle();
        check("req032_data_cnt_sat", {16'h0, bus.data_grant_cnt_o}, 32'h0000_FFFF);
        idle();
        check("req032_data_cnt_held", {16'h0, bus.data_grant_cnt_o}, 32'h0000_FFFF);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
